// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline types for the hazard scheduler
// Forwarding source codes, decode control bundle and redirect FSM state.
package hazard_ctrl_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] addr_t;

  typedef enum logic [2:0] {
    RD      = 3'd0,
    ALUOUTE = 3'd1,
    ALUOUTM = 3'd2,
    MEMDATA = 3'd3,
    WDATA   = 3'd4
  } src_t;

  typedef struct packed {
    logic stall;
    src_t ac;
    src_t bc;
  } supercontrol_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

  function automatic logic dst_hit(input logic valid, input logic regwrite,
                                   input creg_addr_t dst, input creg_addr_t ra);
    return valid & regwrite & (dst == ra);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard scheduler signal bundle
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic          ibus_busy;
  logic          dbus_busy;
  logic          d_valid;
  creg_addr_t    d_ra1;
  creg_addr_t    d_ra2;
  logic          e_valid;
  logic          e_regwrite;
  logic          e_memread;
  creg_addr_t    e_dst;
  logic          m_valid;
  logic          m_regwrite;
  logic          m_memtoreg;
  creg_addr_t    m_dst;
  logic          w_valid;
  logic          w_regwrite;
  creg_addr_t    w_dst;
  logic          e_redirect;
  addr_t         e_target;

  supercontrol_t ctl;
  logic          stall_f;
  logic          stall_d;
  logic          stall_e;
  logic          stall_m;
  logic          flush_d;
  logic          flush_e;
  logic          flush_w;
  logic          f_redirect;
  addr_t         f_target;
  logic          f_discard;

  modport master (
    output ibus_busy, dbus_busy, d_valid, d_ra1, d_ra2,
           e_valid, e_regwrite, e_memread, e_dst,
           m_valid, m_regwrite, m_memtoreg, m_dst,
           w_valid, w_regwrite, w_dst, e_redirect, e_target,
    input  ctl, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, f_redirect, f_target, f_discard
  );

  modport slave (
    input  ibus_busy, dbus_busy, d_valid, d_ra1, d_ra2,
           e_valid, e_regwrite, e_memread, e_dst,
           m_valid, m_regwrite, m_memtoreg, m_dst,
           w_valid, w_regwrite, w_dst, e_redirect, e_target,
    output ctl, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, f_redirect, f_target, f_discard
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - operand forwarding source select for one decode source
// Youngest producing stage wins; loads in E cannot forward (handled as load-use).
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  creg_addr_t ra,
  input  logic       e_valid,
  input  logic       e_regwrite,
  input  logic       e_memread,
  input  creg_addr_t e_dst,
  input  logic       m_valid,
  input  logic       m_regwrite,
  input  logic       m_memtoreg,
  input  creg_addr_t m_dst,
  input  logic       w_valid,
  input  logic       w_regwrite,
  input  creg_addr_t w_dst,
  output src_t       src
);

  always_comb begin
    src = RD;
    if (ra != '0) begin
      if (dst_hit(e_valid, e_regwrite, e_dst, ra) && !e_memread) begin
        src = ALUOUTE;
      end else if (dst_hit(m_valid, m_regwrite, m_dst, ra)) begin
        src = m_memtoreg ? MEMDATA : ALUOUTM;
      end else if (dst_hit(w_valid, w_regwrite, w_dst, ra)) begin
        src = WDATA;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward scheduler for the F/D/E/M/W pipeline
// Optional perf counters (load-use, bus wait, redirects) under HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_lu,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_redir
`endif
);

  hz_state_t state;
  logic      f_redirect_q;
  addr_t     f_target_q;
  logic      f_discard_q;

  src_t ac;
  src_t bc;
  logic lu;
  logic accept;
  logic hold;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  hazard_fwd_sel u_fwd_a (
    .ra(hz.d_ra1),
    .e_valid(hz.e_valid), .e_regwrite(hz.e_regwrite), .e_memread(hz.e_memread), .e_dst(hz.e_dst),
    .m_valid(hz.m_valid), .m_regwrite(hz.m_regwrite), .m_memtoreg(hz.m_memtoreg), .m_dst(hz.m_dst),
    .w_valid(hz.w_valid), .w_regwrite(hz.w_regwrite), .w_dst(hz.w_dst),
    .src(ac)
  );

  hazard_fwd_sel u_fwd_b (
    .ra(hz.d_ra2),
    .e_valid(hz.e_valid), .e_regwrite(hz.e_regwrite), .e_memread(hz.e_memread), .e_dst(hz.e_dst),
    .m_valid(hz.m_valid), .m_regwrite(hz.m_regwrite), .m_memtoreg(hz.m_memtoreg), .m_dst(hz.m_dst),
    .w_valid(hz.w_valid), .w_regwrite(hz.w_regwrite), .w_dst(hz.w_dst),
    .src(bc)
  );

  assign hold   = (state == HZ_HOLD);
  assign lu     = hz.d_valid & hz.e_valid & hz.e_memread & (hz.e_dst != '0) &
                  ((hz.e_dst == hz.d_ra1) | (hz.e_dst == hz.d_ra2));
  // E only holds while dbus is busy; a held E must not redirect twice.
  assign accept = hz.e_redirect & ~stall_e & ~hold;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (hz.dbus_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.ibus_busy) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
    if (accept) begin
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end
    if (hold) begin
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HZ_RUN;
      f_redirect_q <= 1'b0;
      f_target_q   <= '0;
      f_discard_q  <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          f_redirect_q <= accept;
          if (accept) begin
            f_target_q <= hz.e_target;
            if (hz.ibus_busy) begin
              // The outstanding fetch is wrong-path; drop it when it returns.
              state       <= HZ_HOLD;
              f_discard_q <= 1'b1;
            end
          end
        end
        HZ_HOLD: begin
          if (!hz.ibus_busy) begin
            state        <= HZ_RUN;
            f_redirect_q <= 1'b0;
            f_discard_q  <= 1'b0;
          end
        end
        default: begin
          state        <= HZ_RUN;
          f_redirect_q <= 1'b0;
          f_discard_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hz.ctl        = '{stall: lu, ac: ac, bc: bc};
  assign hz.stall_f    = stall_f;
  assign hz.stall_d    = stall_d;
  assign hz.stall_e    = stall_e;
  assign hz.stall_m    = stall_m;
  assign hz.flush_d    = flush_d;
  assign hz.flush_e    = flush_e;
  assign hz.flush_w    = flush_w;
  assign hz.f_redirect = f_redirect_q;
  assign hz.f_target   = f_target_q;
  assign hz.f_discard  = f_discard_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu    <= '0;
      perf_mem   <= '0;
      perf_redir <= '0;
    end else begin
      if (lu && !hz.dbus_busy && perf_lu != '1) begin
        perf_lu <= perf_lu + 1'b1;
      end
      if ((hz.dbus_busy || hz.ibus_busy) && perf_mem != '1) begin
        perf_mem <= perf_mem + 1'b1;
      end
      if (accept && perf_redir != '1) begin
        perf_redir <= perf_redir + 1'b1;
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_mem, perf_redir;
  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .hz(hz),
    .perf_lu(perf_lu), .perf_mem(perf_mem), .perf_redir(perf_redir)
  );
`else
  hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(hz));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a pending-redirect record plus the textual hazard rules.
  logic  mdl_pending, mdl_redir, mdl_disc;
  addr_t mdl_tgt;

  function automatic src_t exp_src(input creg_addr_t ra);
    if (ra == 0) return RD;
    if (hz.e_valid && hz.e_regwrite && !hz.e_memread && hz.e_dst == ra) return ALUOUTE;
    if (hz.m_valid && hz.m_regwrite && hz.m_dst == ra) return hz.m_memtoreg ? MEMDATA : ALUOUTM;
    if (hz.w_valid && hz.w_regwrite && hz.w_dst == ra) return WDATA;
    return RD;
  endfunction

  function automatic logic exp_lu();
    return hz.d_valid && hz.e_valid && hz.e_memread && hz.e_dst != 0 &&
           (hz.e_dst == hz.d_ra1 || hz.e_dst == hz.d_ra2);
  endfunction

  function automatic logic exp_accept();
    return hz.e_redirect && !hz.dbus_busy && !mdl_pending;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_pending = 1'b0;
      mdl_redir   = 1'b0;
      mdl_disc    = 1'b0;
      mdl_tgt     = '0;
    end else if (mdl_pending) begin
      if (!hz.ibus_busy) begin
        mdl_pending = 1'b0;
        mdl_redir   = 1'b0;
        mdl_disc    = 1'b0;
      end
    end else begin
      mdl_redir = exp_accept();
      if (exp_accept()) begin
        mdl_tgt = hz.e_target;
        if (hz.ibus_busy) begin
          mdl_pending = 1'b1;
          mdl_disc    = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic lu, acc, dbus, ibus;
    logic [6:0] want;
    lu   = exp_lu();
    acc  = exp_accept();
    dbus = hz.dbus_busy;
    ibus = hz.ibus_busy;
    chk("m_ctl", hz.ctl, {lu, exp_src(hz.d_ra1), exp_src(hz.d_ra2)});
    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    if (dbus)      want = 7'b1111_001;
    else if (lu)   want = 7'b1100_010;
    else if (ibus) want = 7'b1000_100;
    else           want = 7'b0000_000;
    if (acc) want = (want & 7'b1011_111) | 7'b0000_110;
    if (mdl_pending) want = want | 7'b0000_100;
    chk("m_stall_flush", {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                          hz.flush_d, hz.flush_e, hz.flush_w}, want);
    chk("m_f_redirect", hz.f_redirect, mdl_redir);
    chk("m_f_discard", hz.f_discard, mdl_disc);
    chk("m_f_target", hz.f_target, mdl_tgt);
  end

  task automatic idle();
    hz.ibus_busy = 0; hz.dbus_busy = 0; hz.d_valid = 0; hz.d_ra1 = 0; hz.d_ra2 = 0;
    hz.e_valid = 0; hz.e_regwrite = 0; hz.e_memread = 0; hz.e_dst = 0;
    hz.m_valid = 0; hz.m_regwrite = 0; hz.m_memtoreg = 0; hz.m_dst = 0;
    hz.w_valid = 0; hz.w_regwrite = 0; hz.w_dst = 0;
    hz.e_redirect = 0; hz.e_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fsm(input string tag, input logic redir, input logic disc);
    chk({tag, "_f_redirect"}, hz.f_redirect, redir);
    chk({tag, "_f_discard"}, hz.f_discard, disc);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_ctl", hz.ctl, 7'd0);
    chk("rst_stalls", {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m}, 4'd0);
    chk("rst_flushes", {hz.flush_d, hz.flush_e, hz.flush_w}, 3'd0);
    check_fsm("rst", 1'b0, 1'b0);
    chk("rst_f_target", hz.f_target, 64'd0);
    #1 reset = 1'b0;
    tick();

    // E: addi x5 forwards from ALU output
    hz.e_valid = 1; hz.e_regwrite = 1; hz.e_dst = 5; hz.d_valid = 1; hz.d_ra1 = 5;
    @(negedge clk);
    chk("fwd_e_ac", hz.ctl.ac, ALUOUTE);
    chk("fwd_e_bc", hz.ctl.bc, RD);
    hz.d_ra1 = 0;
    #1 chk("fwd_x0_ac", hz.ctl.ac, RD);
    tick();

    // M load and W write to x7: M wins
    idle();
    hz.m_valid = 1; hz.m_regwrite = 1; hz.m_memtoreg = 1; hz.m_dst = 7;
    hz.w_valid = 1; hz.w_regwrite = 1; hz.w_dst = 7; hz.d_valid = 1; hz.d_ra2 = 7;
    @(negedge clk);
    chk("fwd_m_bc", hz.ctl.bc, MEMDATA);
    tick();

    // Load-use on x3
    idle();
    hz.e_valid = 1; hz.e_regwrite = 1; hz.e_memread = 1; hz.e_dst = 3;
    hz.d_valid = 1; hz.d_ra1 = 3;
    @(negedge clk);
    chk("lu_sfd_fe", {hz.stall_f, hz.stall_d, hz.flush_e, hz.ctl.stall}, 4'hf);
    chk("lu_rest", {hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_w}, 4'h0);
    tick();
    hz.e_valid = 0;
    @(negedge clk);
    chk("lu_gone", {hz.stall_f, hz.stall_d, hz.flush_e, hz.ctl}, 10'd0);
    tick();

    // dbus wait beats load-use for 3 cycles
    hz.e_valid = 1; hz.dbus_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dbus_stalls", {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_w}, 5'h1f);
      chk("dbus_fe", {hz.flush_d, hz.flush_e}, 2'b00);
      tick();
    end

    // Redirect while fetch busy -> HOLD
    idle();
    hz.e_valid = 1; hz.e_redirect = 1; hz.e_target = 64'h8000_0040; hz.ibus_busy = 1;
    @(negedge clk);
    chk("acc_flush", {hz.flush_d, hz.flush_e}, 2'b11);
    check_fsm("acc", 1'b0, 1'b0);
    tick();
    hz.e_redirect = 0; hz.e_valid = 0;
    @(negedge clk);
    check_fsm("hold1", 1'b1, 1'b1);
    chk("hold1_tgt", hz.f_target, 64'h8000_0040);
    tick();
    hz.ibus_busy = 0;
    @(negedge clk);
    check_fsm("hold2", 1'b1, 1'b1);
    chk("hold2_flush_d", hz.flush_d, 1'b1);
    tick();
    @(negedge clk);
    check_fsm("run", 1'b0, 1'b0);
    chk("run_flush_d", hz.flush_d, 1'b0);
    tick();

    // Async reset in HOLD
    hz.e_valid = 1; hz.e_redirect = 1; hz.e_target = 64'h8000_0080; hz.ibus_busy = 1;
    tick();
    idle();
    hz.ibus_busy = 1;
    @(negedge clk);
    check_fsm("hold3", 1'b1, 1'b1);
    #1 hz.ibus_busy = 0; reset = 1'b1;
    #1;
    check_fsm("arst", 1'b0, 1'b0);
    chk("arst_flush_d", hz.flush_d, 1'b0);
    #1 reset = 1'b0;
    tick();

    // Random traffic with small register ids to provoke hits
    for (int c = 0; c < 3000; c++) begin
      hz.ibus_busy  = ($urandom_range(0, 2) == 0);
      hz.dbus_busy  = ($urandom_range(0, 4) == 0);
      hz.d_valid    = $urandom_range(0, 1);
      hz.d_ra1      = 5'($urandom_range(0, 7));
      hz.d_ra2      = 5'($urandom_range(0, 7));
      hz.e_valid    = $urandom_range(0, 1);
      hz.e_regwrite = $urandom_range(0, 1);
      hz.e_memread  = $urandom_range(0, 1);
      hz.e_dst      = 5'($urandom_range(0, 7));
      hz.m_valid    = $urandom_range(0, 1);
      hz.m_regwrite = $urandom_range(0, 1);
      hz.m_memtoreg = $urandom_range(0, 1);
      hz.m_dst      = 5'($urandom_range(0, 7));
      hz.w_valid    = $urandom_range(0, 1);
      hz.w_regwrite = $urandom_range(0, 1);
      hz.w_dst      = 5'($urandom_range(0, 7));
      hz.e_redirect = ($urandom_range(0, 5) == 0);
      hz.e_target   = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
